// File: rtl/c_radix_conversion_test_pkg.sv
// Shared types and constants for the binary/ternary radix conversion block.
// Ternary outputs use a 2-wire thermometer code; inputs use a 2-wire {hi,lo} code.
package c_radix_conversion_test_pkg;

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        MID  = 2'd1,
        HIGH = 2'd2
    } trit_level_t;

    localparam logic [1:0] TRIT_LOW  = 2'b00;
    localparam logic [1:0] TRIT_MID  = 2'b01;
    localparam logic [1:0] TRIT_HIGH = 2'b11;

    localparam int OUT_B_BIN     = 0;
    localparam int OUT_T_BIN     = 1;
    localparam int OUT_B_TRIT_LO = 2;
    localparam int OUT_B_TRIT_HI = 3;
    localparam int OUT_T_TRIT_LO = 4;
    localparam int OUT_T_TRIT_HI = 5;

    // Only the hi wire is trusted, so illegal codes 00/11 fold onto LOW/HIGH.
    function automatic trit_level_t decode_trit(input logic [1:0] code);
        return code[1] ? HIGH : LOW;
    endfunction

    function automatic trit_level_t decode_bin(input logic b);
        return b ? HIGH : LOW;
    endfunction

endpackage

// File: rtl/c_radix_conversion_test_trit_inverter.sv
// Combinational inverter: one level in, inverted binary bit and inverted
// thermometer trit out.
import c_radix_conversion_test_pkg::*;

module trit_inverter (
    input  trit_level_t level,
    output logic        inv_bit,
    output logic [1:0]  inv_trit
);

    always_comb begin
        inv_bit  = 1'b0;
        inv_trit = TRIT_MID;
        case (level)
            LOW: begin
                inv_bit  = 1'b1;
                inv_trit = TRIT_HIGH;
            end
            HIGH: begin
                inv_bit  = 1'b0;
                inv_trit = TRIT_LOW;
            end
            default: begin
                // MID is its own inverse; unreachable from the current decoders.
                inv_bit  = 1'b0;
                inv_trit = TRIT_MID;
            end
        endcase
    end

endmodule

// File: rtl/c_radix_conversion_test.sv
// Registered radix converter: binary and ternary inputs, each inverted into
// binary and thermometer-ternary outputs with one cycle of latency.
import c_radix_conversion_test_pkg::*;

module c_radix_conversion_test (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] io_in,
    output logic [5:0] io_out
);

    trit_level_t b_level;
    trit_level_t t_level;
    logic        b_inv_bit;
    logic        t_inv_bit;
    logic [1:0]  b_inv_trit;
    logic [1:0]  t_inv_trit;
    logic [5:0]  out_next;
    logic [5:0]  out_reg;

    assign b_level = decode_bin(io_in[0]);
    assign t_level = decode_trit(io_in[2:1]);

    trit_inverter u_inv_b (
        .level    (b_level),
        .inv_bit  (b_inv_bit),
        .inv_trit (b_inv_trit)
    );

    trit_inverter u_inv_t (
        .level    (t_level),
        .inv_bit  (t_inv_bit),
        .inv_trit (t_inv_trit)
    );

    always_comb begin
        out_next                               = '0;
        out_next[OUT_B_BIN]                    = b_inv_bit;
        out_next[OUT_T_BIN]                    = t_inv_bit;
        out_next[OUT_B_TRIT_HI:OUT_B_TRIT_LO]  = b_inv_trit;
        out_next[OUT_T_TRIT_HI:OUT_T_TRIT_LO]  = t_inv_trit;
    end

    // Every output bit comes straight from a flop so it cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= '0;
        end else begin
            out_reg <= out_next;
        end
    end

    assign io_out = out_reg;

endmodule

// File: tb/tb_c_radix_conversion_test.sv
// Scoreboard bench for c_radix_conversion_test: stimulus queues expected
// results, a monitor checks them one cycle later.
module tb_c_radix_conversion_test;

    logic       clk;
    logic       rst;
    logic [2:0] io_in;
    logic [5:0] io_out;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];

    c_radix_conversion_test dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: io_out=%02h expected=%02h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: io_out=%02h", name, act);
        end
    endtask

    task automatic apply(input logic [2:0] v, input logic [5:0] e, input string name);
        exp_t item;
        @(negedge clk);
        io_in     = v;
        item.exp  = e;
        item.name = name;
        sb.push_back(item);
    endtask

    // Monitor: one conversion per rising edge, checked just after it.
    initial begin
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                item = sb.pop_front();
                check(item.name, io_out, item.exp);
            end
        end
    end

    initial begin
        exp_t item;
        int   budget;
        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        io_in = 3'b111;
        #1;
        check("reset_t0", io_out, 6'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", io_out, 6'h00);
        end

        // Release reset; the very first edge must load io_in=000.
        @(negedge clk);
        rst       = 1'b0;
        io_in     = 3'b000;
        item.exp  = 6'h3F;
        item.name = "first_after_release_000";
        sb.push_back(item);

        apply(3'b010, 6'h3F, "t01_b0");
        #1;
        check("hold_before_edge", io_out, 6'h3F);

        apply(3'b111, 6'h00, "illegal_t11_b1");
        apply(3'b101, 6'h00, "t10_b1");
        apply(3'b001, 6'h32, "t00_b1");
        apply(3'b100, 6'h0D, "t10_b0");
        apply(3'b011, 6'h32, "t01_b1_lo_wire_ignored");
        apply(3'b110, 6'h0D, "t11_b0");
        apply(3'b000, 6'h3F, "all_low");

        // Asynchronous reset between edges while io_out=3F.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_no_edge", io_out, 6'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_hold_mid", io_out, 6'h00);
        end
        @(negedge clk);
        rst   = 1'b0;
        io_in = 3'b000;
        #1;
        check("released_before_edge", io_out, 6'h00);
        item.exp  = 6'h3F;
        item.name = "first_after_rerelease";
        sb.push_back(item);

        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/c_radix_conversion_test.md
C_RADIX_CONVERSION_TEST -- requirements
Module: c_radix_conversion_test

Interface
REQ-001 The module SHALL have no parameters; widths are fixed.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 io_in  input  3  io_in[0] = binary input B; io_in[2:1] = ternary input T as a 2-wire code {hi,lo}.
REQ-005 io_out  output  6  registered conversion results, mapped per REQ-008..REQ-011.

Function
REQ-006 Ternary input decode SHALL use io_in[2] only.
- io_in[2]=0 gives LOW; codes 01 (legal) and 00 (illegal, tolerated) both decode LOW.
- io_in[2]=1 gives HIGH; codes 10 (legal) and 11 (illegal, tolerated) both decode HIGH.
- io_in[1] SHALL NOT affect any output.
REQ-007 The binary input SHALL decode as B=0 LOW, B=1 HIGH.
REQ-008 io_out[0] SHALL be the binary inverse of B: binary to binary NOT.
REQ-009 io_out[1] SHALL be the binary inverse of the decoded T: ternary to binary NOT.
REQ-010 io_out[3:2] SHALL be the thermometer ternary code of NOT(B): 2'b11 when B is LOW, 2'b00 when B is HIGH (binary to ternary).
REQ-011 io_out[5:4] SHALL be the thermometer ternary code of NOT(decoded T): 2'b11 when T is LOW, 2'b00 when T is HIGH (ternary to ternary).
REQ-012 The output ternary code SHALL be thermometer: 00=LOW, 01=MID, 11=HIGH; 10 is never driven; MID is never produced by this block.
REQ-013 Consequence of REQ-008..REQ-011: all inputs LOW gives io_out=6'h3F; all inputs HIGH gives io_out=6'h00.
REQ-014 Latency SHALL be exactly one clk cycle.
- io_in is sampled on a rising edge.
- io_out reflects that sample immediately after the same edge.
- No handshake; a new conversion occurs every cycle.
REQ-015 Each output bit SHALL depend only on its own source (B or decoded T).
- A change on B SHALL NOT alter io_out[1] or io_out[5:4].
- A change on io_in[2] SHALL NOT alter io_out[0] or io_out[3:2].
REQ-016 Outputs SHALL be glitch-free between edges: each bit is driven directly by a flop.

Reset
REQ-017 While rst=1, io_out SHALL be 6'h00 immediately, independent of clk.
REQ-018 Reset asserted mid-operation SHALL discard the pending sample.
REQ-019 On the first rising edge after rst deasserts, io_out SHALL load the conversion of the current io_in.

Structure
REQ-020 A shared package SHALL hold:
- the ternary level enum LOW/MID/HIGH;
- constants for output codes TRIT_LOW=2'b00, TRIT_MID=2'b01, TRIT_HIGH=2'b11;
- the io_out bit-field index constants.
REQ-021 One sub-module, trit_inverter, SHALL be used.
- It is instantiated twice: once fed from B, once from decoded T.
- Each instance takes one level and produces the inverted binary bit plus the inverted 2-bit thermometer code.
- It is combinational; the register stage lives in the top module.

Verification
REQ-022 rst=1, then io_in=3'b111 with clocks running -> io_out=6'h00 throughout reset.
REQ-023 Release reset; io_in=3'b000 (illegal ternary 00), one edge -> io_out=6'h3F.
REQ-024 io_in=3'b010 (T=01, B=0), one edge -> io_out=6'h3F; the bench checks io_out is unchanged before that edge.
REQ-025 Illegal ternary 11 with B=1:
- io_in=3'b111, one edge -> io_out=6'h00;
- then io_in=3'b101 (legal T=10), one edge -> io_out=6'h00.
REQ-026 Mixed inputs:
- io_in=3'b001 (B=1, T=00) -> io_out=6'h32;
- io_in=3'b100 (B=0, T=10) -> io_out=6'h0D.
REQ-027 Assert rst between edges while io_out=6'h3F -> io_out=6'h00 with no clk edge, and stays 6'h00 until the first edge after release.
